barrel_unshifter: RTL and testbench
===================================

Name: barrel_unshifter

Overview:
- Sequential inverse of the team's 4-bit barrel shifter.
- Accepts a shifted or rotated word plus the op descriptor that produced it (select, direction, shift_value).
- Iteratively applies the opposite operation, one bit position per cycle, and returns the recovered word over a valid/ready handshake.
- Sits on the receive side of a shifter datapath. Used to reconstruct operands and to cross-check the forward shifter.

Parameters:
- WIDTH, 4, data width in bits; must be ≥2.
- SHAMT_W, $clog2(WIDTH), width of shift_value.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word and descriptor valid.
- in_ready  out  1  block can accept an input (IDLE only).
- select  in  1  forward op: 0 = shift (zero-fill), 1 = rotate.
- direction  in  1  forward direction: 0 = right, 1 = left.
- shift_value  in  SHAMT_W  forward shift/rotate amount.
- din  in  WIDTH  word produced by the forward shifter.
- out_valid  out  1  recovered word valid.
- out_ready  in  1  consumer accepts output.
- dout  out  WIDTH  recovered word.
- out_lossy  out  1  recovery incomplete: shift op with shift_value≠0 (filled bits unrecoverable).

Behaviour:
- Reset (async assert, sync-safe deassert): state=IDLE, dout=0, out_valid=0, out_lossy=0, internal count=0. in_ready=1 after reset.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch din into the data register, latch op/dir/count=shift_value, and compute lossy=(select==0 && shift_value!=0).
  - Next state: DONE if shift_value==0, else RUN.
- RUN:
  - in_ready=0.
  - Each edge applies one inverse step to the data register and decrements count; when count reaches 0, go to DONE.
  - Inverse step per forward op:
    - rotate right → rotate left 1;
    - rotate left → rotate right 1;
    - shift right → shift left 1, LSB=0;
    - shift left → logical shift right 1, MSB=0.
- DONE:
  - out_valid=1; dout and out_lossy hold stable while out_ready=0.
  - On out_valid&out_ready, go to IDLE and clear out_valid. dout keeps its last value.
- Latency: out_valid asserts shift_value cycles after the accept edge (shift_value=0 → asserts immediately after the accept edge).
- Throughput: one transaction in flight. No new accept in the output handshake cycle; in_ready rises the cycle after.
- Input signals are ignored outside IDLE. in_valid dropped without acceptance has no effect.
- shift_value ≥ WIDTH (when WIDTH is not a power of 2): rotate uses shift_value mod WIDTH; shift result is all zeros, lossy=1.
- Reset asserted mid-RUN or mid-DONE: transaction discarded; all outputs return to reset values immediately.

Optional Feature:
- Macro: BARREL_UNSHIFT_FASTPATH_EN.
- Defined:
  - The full inverse is computed combinationally from the latched descriptor in the accept cycle.
  - State goes IDLE→DONE directly; latency is 0 extra cycles for every shift_value.
  - RUN is unreachable.
- Undefined: the iterative one-bit-per-cycle behaviour above.
- Handshake, lossy semantics and reset behaviour are identical in both builds.

Decomposition:
- Package barrel_pkg holds:
  - enum op_e {OP_SHIFT=0, OP_ROTATE=1};
  - enum dir_e {DIR_RIGHT=0, DIR_LEFT=1};
  - enum state_e {ST_IDLE, ST_RUN, ST_DONE}.
- Sub-module barrel_unshift_step: combinational one-position inverse step (inputs data, op, dir; output stepped data). It is reused by the fast path via a generate loop.

Test Plan (WIDTH=4, fast path off):
- Rotate-right inverse: select=1 dir=0 shamt=1 din=1101 → dout=1011, out_lossy=0, out_valid 1 cycle after accept.
- Rotate-left inverse: select=1 dir=1 shamt=2 din=1110 → dout=1011, lossy=0, 2-cycle latency. Repeat with shamt=3, din=1101 → 1011.
- Shift inverses:
  - select=0 dir=0 shamt=2 din=0001 → dout=0100, lossy=1.
  - select=0 dir=1 shamt=3 din=1000 → dout=0001, lossy=1, 3-cycle latency.
- Zero amount: select=0 shamt=0 din=1010 → dout=1010, lossy=0, out_valid immediately after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → dout/out_lossy stable, in_ready=0, in_valid pulses ignored. Release → handshake, IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 one cycle into a shamt=3 rotate → out_valid=0, dout=0, in_ready=1 after release. Next transaction completes correctly.

Source files
------------

// File: rtl/barrel_pkg.sv
// Shared types for the barrel-unshifter: forward-op encodings and FSM states.
package barrel_pkg;

  typedef enum logic {
    OP_SHIFT  = 1'b0,
    OP_ROTATE = 1'b1
  } op_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_unshift_step.sv
// One-position inverse of a forward shift/rotate: undoes a single bit of movement.
module barrel_unshift_step
  import barrel_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  dir_e             dir_i,
  output logic [WIDTH-1:0] data_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    data_o = data_i;
    case ({op_i, dir_i})
      {OP_ROTATE, DIR_RIGHT}: data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
      {OP_ROTATE, DIR_LEFT}:  data_o = {data_i[0], data_i[WIDTH-1:1]};
      {OP_SHIFT,  DIR_RIGHT}: data_o = {data_i[WIDTH-2:0], 1'b0};
      {OP_SHIFT,  DIR_LEFT}:  data_o = {1'b0, data_i[WIDTH-1:1]};
      default:                data_o = data_i;
    endcase
  end

endmodule

// File: rtl/barrel_unshifter.sv
// Sequential inverse of the 4-bit barrel shifter with valid/ready on both sides.
// Optional BARREL_UNSHIFT_FASTPATH_EN: full inverse computed at accept, IDLE->DONE directly.
module barrel_unshifter
  import barrel_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               select,
  input  logic               direction,
  input  logic [SHAMT_W-1:0] shift_value,
  input  logic [WIDTH-1:0]   din,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               out_lossy
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  op_e                op_q, op_d;
  dir_e               dir_q, dir_d;
  logic               lossy_q, lossy_d;

  logic               accept;
  logic [WIDTH-1:0]   step_data;
  logic [WIDTH-1:0]   accept_data;

  assign accept = in_valid & in_ready;

  barrel_unshift_step #(.WIDTH(WIDTH)) u_step (
    .data_i (data_q),
    .op_i   (op_q),
    .dir_i  (dir_q),
    .data_o (step_data)
  );

`ifdef BARREL_UNSHIFT_FASTPATH_EN
  localparam int NSTEPS = 2 ** SHAMT_W - 1;
  logic [WIDTH-1:0] chain [NSTEPS+1];

  // Unrolled chain of single steps; stage k holds the word undone by k positions.
  assign chain[0] = din;
  for (genvar k = 0; k < NSTEPS; k++) begin : g_fast
    barrel_unshift_step #(.WIDTH(WIDTH)) u_fstep (
      .data_i (chain[k]),
      .op_i   (op_e'(select)),
      .dir_i  (dir_e'(direction)),
      .data_o (chain[k+1])
    );
  end
  assign accept_data = chain[shift_value];
`else
  assign accept_data = din;
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      count_q <= '0;
      op_q    <= OP_SHIFT;
      dir_q   <= DIR_RIGHT;
      lossy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      op_q    <= op_d;
      dir_q   <= dir_d;
      lossy_q <= lossy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef BARREL_UNSHIFT_FASTPATH_EN
          state_d = ST_DONE;
`else
          state_d = (shift_value == '0) ? ST_DONE : ST_RUN;
`endif
        end
      end
      ST_RUN:  if (count_q == SHAMT_W'(1)) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    dout      = data_q;
    out_lossy = lossy_q;
  end

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    op_d    = op_q;
    dir_d   = dir_q;
    lossy_d = lossy_q;
    if (accept) begin
      data_d  = accept_data;
      count_d = shift_value;
      op_d    = op_e'(select);
      dir_d   = dir_e'(direction);
      lossy_d = (select == 1'b0) && (shift_value != '0);
    end else if (state_q == ST_RUN) begin
      data_d  = step_data;
      count_d = count_q - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_barrel_unshifter.sv
// Directed bench for barrel_unshifter (WIDTH=4, iterative build).
module tb_barrel_unshifter;

  localparam int WIDTH   = 4;
  localparam int SHAMT_W = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               select;
  logic               direction;
  logic [SHAMT_W-1:0] shift_value;
  logic [WIDTH-1:0]   din;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   dout;
  logic               out_lossy;

  int n_compared   = 0;
  int n_mismatched = 0;

  barrel_unshifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .select      (select),
    .direction   (direction),
    .shift_value (shift_value),
    .din         (din),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .out_lossy   (out_lossy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one word, waits (bounded) for out_valid, captures outputs, completes the handshake.
  task automatic run_txn(input logic sel, input logic dir, input logic [SHAMT_W-1:0] sh,
                         input logic [WIDTH-1:0] d, input bit finish_hs,
                         output logic [WIDTH-1:0] got_dout, output logic got_lossy,
                         output int lat);
    select = sel; direction = dir; shift_value = sh; din = d; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    got_dout  = dout;
    got_lossy = out_lossy;
    if (finish_hs) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  task automatic check_txn(input string name, input logic [WIDTH-1:0] got_d,
                           input logic got_l, input int lat,
                           input logic [WIDTH-1:0] exp_d, input logic exp_l, input int exp_lat);
    if (got_d !== exp_d) begin
      $display("FAIL %s dout: got %b expected %b", name, got_d, exp_d);
      n_mismatched++;
    end
    n_compared++;
    if (got_l !== exp_l) begin
      $display("FAIL %s lossy: got %b expected %b", name, got_l, exp_l);
      n_mismatched++;
    end
    n_compared++;
    if (lat !== exp_lat) begin
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      n_mismatched++;
    end
    n_compared++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    select = 1'b0; direction = 1'b0; shift_value = '0; din = '0;
    #12;
    if ({in_ready, out_valid, dout, out_lossy} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
      $display("FAIL reset_state: got rdy=%b vld=%b dout=%b lossy=%b expected 1 0 0000 0",
               in_ready, out_valid, dout, out_lossy);
      n_mismatched++;
    end
    n_compared++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rotate();
    logic [WIDTH-1:0] d; logic l; int lat;
    run_txn(1'b1, 1'b0, 2'd1, 4'b1101, 1'b1, d, l, lat);
    check_txn("rot_right_1", d, l, lat, 4'b1011, 1'b0, 1);
    run_txn(1'b1, 1'b1, 2'd2, 4'b1110, 1'b1, d, l, lat);
    check_txn("rot_left_2", d, l, lat, 4'b1011, 1'b0, 2);
    run_txn(1'b1, 1'b1, 2'd3, 4'b1101, 1'b1, d, l, lat);
    check_txn("rot_left_3", d, l, lat, 4'b1011, 1'b0, 3);
  endtask

  task automatic test_shift();
    logic [WIDTH-1:0] d; logic l; int lat;
    run_txn(1'b0, 1'b0, 2'd2, 4'b0001, 1'b1, d, l, lat);
    check_txn("shift_right_2", d, l, lat, 4'b0100, 1'b1, 2);
    run_txn(1'b0, 1'b1, 2'd3, 4'b1000, 1'b1, d, l, lat);
    check_txn("shift_left_3", d, l, lat, 4'b0001, 1'b1, 3);
  endtask

  task automatic test_zero_amount();
    logic [WIDTH-1:0] d; logic l; int lat;
    run_txn(1'b0, 1'b0, 2'd0, 4'b1010, 1'b1, d, l, lat);
    check_txn("zero_shift", d, l, lat, 4'b1010, 1'b0, 0);
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 4'b1010) begin
      $display("FAIL post_handshake: got rdy=%b vld=%b dout=%b expected 1 0 1010",
               in_ready, out_valid, dout);
      n_mismatched++;
    end
    n_compared++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] d; logic l; int lat;
    run_txn(1'b0, 1'b1, 2'd1, 4'b0110, 1'b0, d, l, lat);
    check_txn("bp_shift_left_1", d, l, lat, 4'b0011, 1'b1, 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; select = 1'b1; shift_value = 2'd2; din = 4'(c + 5);
      tick();
      if ({out_valid, in_ready, dout, out_lossy} !== {1'b1, 1'b0, 4'b0011, 1'b1}) begin
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b dout=%b lossy=%b expected 1 0 0011 1",
                 c, out_valid, in_ready, dout, out_lossy);
        n_mismatched++;
      end
      n_compared++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if ({out_valid, in_ready, dout} !== {1'b0, 1'b1, 4'b0011}) begin
      $display("FAIL bp_release: got vld=%b rdy=%b dout=%b expected 0 1 0011",
               out_valid, in_ready, dout);
      n_mismatched++;
    end
    n_compared++;
  endtask

  task automatic test_reset_mid_run();
    logic [WIDTH-1:0] d; logic l; int lat;
    select = 1'b1; direction = 1'b1; shift_value = 2'd3; din = 4'b1101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    if (in_ready !== 1'b0) begin
      $display("FAIL mid_run_busy: got rdy=%b expected 0", in_ready);
      n_mismatched++;
    end
    n_compared++;
    rst_n = 1'b0;
    #1;
    if ({out_valid, dout, in_ready, out_lossy} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
      $display("FAIL mid_run_reset: got vld=%b dout=%b rdy=%b lossy=%b expected 0 0000 1 0",
               out_valid, dout, in_ready, out_lossy);
      n_mismatched++;
    end
    n_compared++;
    #7;
    rst_n = 1'b1;
    tick();
    run_txn(1'b1, 1'b0, 2'd1, 4'b1101, 1'b1, d, l, lat);
    check_txn("after_reset_rot", d, l, lat, 4'b1011, 1'b0, 1);
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_shift();
    test_zero_amount();
    test_backpressure();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
